// File: rtl/viewport_fetch_if.sv
// Bundled scroll-input, canvas-RAM read port and pixel-stream signals for viewport_fetch.
interface viewport_fetch_if #(
  parameter int unsigned AW = 13
);
  logic [10:0]   col_offset;
  logic          frame_start;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          frame_drop;
  logic          off_err;

  // Fetch engine side
  modport master (
    input  col_offset, frame_start, mem_rdata, out_ready,
    output mem_addr, mem_re, out_data, out_valid, out_last, busy, frame_drop, off_err
  );

  // Scroll controller / RAM / serialiser side
  modport slave (
    output col_offset, frame_start, mem_rdata, out_ready,
    input  mem_addr, mem_re, out_data, out_valid, out_last, busy, frame_drop, off_err
  );
endinterface

// File: rtl/viewport_fetch.sv
// Streams one VIEW_W-wide window of the page-organised canvas RAM per frame request,
// using a col_offset snapshot taken at frame acceptance. Canvas columns wrap modulo CANVAS_W.
module viewport_fetch #(
  parameter int unsigned CANVAS_W = 896,
  parameter int unsigned VIEW_W   = 128,
  parameter int unsigned PAGES    = 8,
  parameter int unsigned AW       = 13
) (
  input  logic              clk,
  input  logic              rst,
  viewport_fetch_if.master  bus
);

  localparam int unsigned OW    = 11;
  localparam int unsigned SW    = 12;
  localparam int unsigned CW    = (VIEW_W > 1) ? $clog2(VIEW_W) : 1;
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTRW  = 2;
  localparam int unsigned CNTW  = 3;
  localparam int unsigned EW    = 9;

  localparam logic [SW-1:0] CANVAS_S  = SW'(CANVAS_W);
  localparam logic [OW-1:0] CANVAS_O  = OW'(CANVAS_W);
  localparam logic [CW-1:0] COL_LAST  = CW'(VIEW_W - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    off_q, off_d;
  logic [CW-1:0]    col_q, col_d;
  logic [PW-1:0]    page_q, page_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic             mem_re_q, mem_re_d;
  logic             re_last_q, re_last_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_last_q, rd_last_d;
  logic [EW-1:0]    fifo_q [DEPTH];
  logic [EW-1:0]    fifo_d [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;

  logic             off_bad;
  logic [OW-1:0]    off_new;
  logic [OW-1:0]    off_sel;
  logic [CW-1:0]    col_sel;
  logic [PW-1:0]    page_sel;
  logic [SW-1:0]    c_sum;
  logic [SW-1:0]    c_wrap;
  logic [AW-1:0]    addr_c;
  logic             sel_last;
  logic             room;
  logic             issue;
  logic             push;
  logic             pop;

  // Address of the next read; in IDLE it is beat 0 of the frame being accepted
  always_comb begin
    off_bad  = (bus.col_offset >= CANVAS_O);
    off_new  = off_bad ? '0 : bus.col_offset;
    off_sel  = (state_q == S_IDLE) ? off_new : off_q;
    col_sel  = (state_q == S_IDLE) ? '0 : col_q;
    page_sel = (state_q == S_IDLE) ? '0 : page_q;
    c_sum    = SW'(off_sel) + SW'(col_sel);
    c_wrap   = (c_sum >= CANVAS_S) ? (c_sum - CANVAS_S) : c_sum;
    addr_c   = (AW'(page_sel) * AW'(CANVAS_W)) + AW'(c_wrap);
    sel_last = (page_sel == PAGE_LAST) && (col_sel == COL_LAST);
  end

  // Frame FSM, read issue and window counters
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    col_d      = col_q;
    page_d     = page_q;
    mem_addr_d = mem_addr_q;
    mem_re_d   = 1'b0;
    re_last_d  = 1'b0;
    rd_vld_d   = mem_re_q;
    rd_last_d  = re_last_q;
    busy_d     = busy_q;
    drop_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    pop        = valid_q && bus.out_ready;
    // Outstanding reads never exceed the free FIFO slots
    room       = (cnt_q + CNTW'(mem_re_q)) <= CNTW'(2);

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          off_d   = off_new;
          err_d   = off_bad;
          busy_d  = 1'b1;
          issue   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        drop_d = bus.frame_start;
        issue  = room;
      end
      S_DRAIN: begin
        drop_d = bus.frame_start;
        if (pop && head_q[EW-1]) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      mem_addr_d = addr_c;
      mem_re_d   = 1'b1;
      re_last_d  = sel_last;
      if (col_sel == COL_LAST) begin
        col_d  = '0;
        page_d = page_sel + PW'(1);
      end else begin
        col_d  = col_sel + CW'(1);
        page_d = page_sel;
      end
      if (sel_last) begin
        state_d = S_DRAIN;
      end
    end
  end

  // Output FIFO; the head is re-registered so out_data/out_last come straight from flops
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = rd_vld_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {rd_last_q, bus.mem_rdata};
      wr_ptr_d         = wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
    head_d  = fifo_d[rd_ptr_d];
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      col_q      <= '0;
      page_q     <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      re_last_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      col_q      <= col_d;
      page_q     <= page_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      re_last_q  <= re_last_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.out_data   = head_q[7:0];
  assign bus.out_last   = valid_q & head_q[EW-1];
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_drop = drop_q;
  assign bus.off_err    = err_q;

endmodule

// File: tb/tb_viewport_fetch.sv
// Randomised scoreboard bench for viewport_fetch: a window/wrap reference model fills
// expected read-address and beat queues; monitors pop and compare as the DUT produces them.
module tb_viewport_fetch;

  localparam int unsigned CANVAS_W = 896;
  localparam int unsigned VIEW_W   = 128;
  localparam int unsigned PAGES    = 8;
  localparam int unsigned AW       = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rand_mode = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int drop_cnt = 0;
  int err_cnt = 0;
  int beats_seen = 0;

  logic [AW-1:0] exp_addr [$];
  logic [8:0]    exp_beat [$];

  always #5 clk = ~clk;

  viewport_fetch_if #(.AW(AW)) vif ();

  viewport_fetch #(
    .CANVAS_W(CANVAS_W), .VIEW_W(VIEW_W), .PAGES(PAGES), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  // Canvas RAM contents are a hash of the address
  function automatic logic [7:0] hash(input logic [AW-1:0] a);
    logic [15:0] x;
    x = ({3'b000, a} * 16'd167) + 16'h003C;
    return x[7:0] ^ x[15:8];
  endfunction

  // Synchronous-read RAM model: data one cycle after mem_re is sampled
  always @(posedge clk) begin
    if (vif.mem_re) vif.mem_rdata <= hash(vif.mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event not expected at this point", name);
  endtask

  // Reference model: the full frame for a given requested offset
  task automatic push_frame(input int unsigned off_in);
    int unsigned off;
    int unsigned a;
    off = (off_in >= CANVAS_W) ? 0 : off_in;
    for (int p = 0; p < PAGES; p++) begin
      for (int c = 0; c < VIEW_W; c++) begin
        a = p * CANVAS_W + ((off + c) % CANVAS_W);
        exp_addr.push_back(AW'(a));
        exp_beat.push_back({(p == PAGES - 1) && (c == VIEW_W - 1), hash(AW'(a))});
      end
    end
  endtask

  // out_ready driver: held high, or random 50% duty
  initial begin
    vif.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      vif.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: read addresses, beats, stall stability and pulse counts
  initial begin
    logic       prev_valid;
    logic       prev_ready;
    logic [8:0] prev_beat;
    logic [8:0] eb;
    logic [AW-1:0] ea;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        if (vif.frame_drop) drop_cnt++;
        if (vif.off_err) err_cnt++;
        if (vif.mem_re) begin
          if (exp_addr.size() == 0) fail_now("unexpected_read");
          else begin
            ea = exp_addr.pop_front();
            check("mem_addr", 32'(vif.mem_addr), 32'(ea));
          end
        end
        if (prev_valid && !prev_ready) begin
          check("stall_hold", {22'd0, vif.out_valid, vif.out_last, vif.out_data},
                {22'd0, 1'b1, prev_beat});
        end
        if (vif.out_valid && vif.out_ready) begin
          if (exp_beat.size() == 0) fail_now("unexpected_beat");
          else begin
            eb = exp_beat.pop_front();
            check("beat", {23'd0, vif.out_last, vif.out_data}, {23'd0, eb});
          end
          beats_seen++;
        end
        prev_valid = vif.out_valid;
        prev_ready = vif.out_ready;
        prev_beat  = {vif.out_last, vif.out_data};
      end
    end
  end

  // Pulse frame_start; the sampling edge is the reference point for cycle counts
  task automatic start_frame(input int unsigned off_v, input bit accept);
    @(negedge clk);
    vif.col_offset  = 11'(off_v);
    vif.frame_start = 1'b1;
    if (accept) push_frame(off_v);
    @(posedge clk);
    #1;
    vif.frame_start = 1'b0;
  endtask

  // Edges until busy is seen low, and until out_valid is first seen high
  task automatic wait_idle(input int limit, output int n, output int first_v);
    n = 0;
    first_v = -1;
    forever begin
      @(negedge clk);
      if (vif.out_valid && first_v < 0) first_v = n;
      if (!vif.busy) break;
      if (n >= limit) begin
        fail_now("busy_timeout");
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int fv;
    int d0;
    int e0;
    int b0;
    int k;
    vif.col_offset  = '0;
    vif.frame_start = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {6'd0, vif.mem_addr, vif.mem_re, vif.out_data, vif.out_valid, vif.out_last,
           vif.busy, vif.frame_drop, vif.off_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Offset 0, sink always ready: latency and frame length
    start_frame(0, 1'b1);
    wait_idle(3000, n, fv);
    check("t1_busy_cycles", 32'(n), 32'd1026);
    check("t1_first_valid", 32'(fv), 32'd2);
    check("t1_drained", 32'(exp_beat.size()), 32'd0);

    // Offsets 640 and 800 (the latter wraps inside each page)
    start_frame(640, 1'b1);
    wait_idle(3000, n, fv);
    start_frame(800, 1'b1);
    wait_idle(3000, n, fv);

    // Offset changes mid-frame and a second request while busy
    d0 = drop_cnt;
    start_frame(128, 1'b1);
    repeat (300) @(negedge clk);
    start_frame(130, 1'b0);
    wait_idle(3000, n, fv);
    repeat (20) @(negedge clk);
    check("t4_drop_count", 32'(drop_cnt - d0), 32'd1);
    check("t4_idle", {30'd0, vif.busy, vif.out_valid}, 32'd0);

    // Request coinciding with the final beat transfer is dropped
    d0 = drop_cnt;
    start_frame(0, 1'b1);
    k = 0;
    forever begin
      @(negedge clk);
      if (vif.out_valid && vif.out_last) break;
      k++;
      if (k > 3000) begin
        fail_now("last_beat_timeout");
        break;
      end
    end
    vif.col_offset  = 11'd5;
    vif.frame_start = 1'b1;
    @(posedge clk);
    #1;
    vif.frame_start = 1'b0;
    repeat (20) @(negedge clk);
    check("t4b_drop_count", 32'(drop_cnt - d0), 32'd1);
    check("t4b_idle", {30'd0, vif.busy, vif.out_valid}, 32'd0);

    // Random back-pressure with random offsets
    rand_mode = 1'b1;
    for (int f = 0; f < 2; f++) begin
      start_frame($urandom_range(0, CANVAS_W - 1), 1'b1);
      wait_idle(8000, n, fv);
    end
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_drained", 32'(exp_beat.size() + exp_addr.size()), 32'd0);

    // Asynchronous reset mid-frame, then a clean frame
    b0 = beats_seen;
    start_frame(0, 1'b1);
    k = 0;
    while ((beats_seen - b0) < 500 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail_now("beat500_timeout");
    #3;
    rst = 1'b0;
    #1;
    check("t6a_reset_outputs",
          {6'd0, vif.mem_addr, vif.mem_re, vif.out_data, vif.out_valid, vif.out_last,
           vif.busy, vif.frame_drop, vif.off_err}, 32'd0);
    exp_addr.delete();
    exp_beat.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_frame(0, 1'b1);
    wait_idle(3000, n, fv);
    check("t6a_busy_cycles", 32'(n), 32'd1026);

    // Out-of-range offset is clamped to 0 and flagged
    e0 = err_cnt;
    start_frame(1000, 1'b1);
    wait_idle(3000, n, fv);
    check("t6b_off_err", 32'(err_cnt - e0), 32'd1);

    repeat (5) @(negedge clk);
    check("final_queues_empty", 32'(exp_beat.size() + exp_addr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
